vga_fb_scheduler: RTL

VGA_FB_SCHEDULER -- requirements
Module: vga_fb_scheduler

---
 rtl/vga_fb_scheduler.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/vga_fb_scheduler.sv
// Framebuffer RAM scheduler: display reads own every 4th active cycle; the rest
// go to a background clear engine or the host port, with a 3-cycle pixel pipe.
//
// state | meaning
// IDLE  | host may use free RAM cycles
// CLEAR | free RAM cycles write clrColor to consecutive words, host locked out
module vga_fb_scheduler #(
  parameter int FB_WORDS   = 76800,
  parameter int LINE_WORDS = 160
) (
  input  logic        ckVideo,
  input  logic        rstVideoN,
  input  logic [9:0]  adrHor,
  input  logic [9:0]  adrVer,
  input  logic        flgActiveVideo,
  input  logic        HS,
  input  logic        VS,
  output logic [3:0]  pixOut,
  output logic        flgActiveOut,
  output logic        HSOut,
  output logic        VSOut,
  output logic        memEn,
  output logic        memWe,
  output logic [16:0] memAdr,
  output logic [15:0] memWrData,
  input  logic [15:0] memRdData,
  input  logic        hostReq,
  input  logic        hostWe,
  input  logic [16:0] hostAdr,
  input  logic [15:0] hostWrData,
  output logic        hostAck,
  output logic [15:0] hostRdData,
  output logic        hostRdValid,
  input  logic        clrStart,
  input  logic [3:0]  clrColor,
  output logic        clrBusy,
  output logic        clrDone
);

  localparam logic [16:0] FB_LAST = 17'(FB_WORDS - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t      state;
  logic [16:0] clrAdr;
  logic [3:0]  clrColorReg;

  logic        dispSlot;
  logic [16:0] dispAdr;
  logic        hostInRange;
  logic        clrGrant;
  logic        hostGrant;

  logic        rdInRange;

  logic [1:0]  pixSel1, pixSel2;
  logic        act1, act2, hs1, hs2, vs1, vs2;
  logic        dispPend;
  logic [15:0] dispWord;

  // Arbitration: display slot first, then clear, then host.
  always_comb begin
    dispSlot    = flgActiveVideo && (adrHor[1:0] == 2'b00);
    dispAdr     = 17'(adrVer) * 17'(LINE_WORDS) + 17'(adrHor[9:2]);
    hostInRange = hostAdr <= FB_LAST;
    clrGrant    = rstVideoN && !dispSlot && (state == CLEAR);
    hostGrant   = rstVideoN && !dispSlot && (state == IDLE) && hostReq;

    memEn     = 1'b0;
    memWe     = 1'b0;
    memAdr    = '0;
    memWrData = '0;
    if (rstVideoN && dispSlot) begin
      memEn  = 1'b1;
      memAdr = dispAdr;
    end else if (clrGrant) begin
      memEn     = 1'b1;
      memWe     = 1'b1;
      memAdr    = clrAdr;
      memWrData = {4{clrColorReg}};
    end else if (hostGrant) begin
      memEn     = hostInRange;
      memWe     = hostWe;
      memAdr    = hostAdr;
      memWrData = hostWrData;
    end
  end

  assign hostAck = hostGrant;

  always_ff @(posedge ckVideo) begin
    if (!rstVideoN) begin
      state       <= IDLE;
      clrAdr      <= '0;
      clrBusy     <= 1'b0;
      clrDone     <= 1'b0;
      clrColorReg <= '0;
    end else begin
      clrDone <= 1'b0;
      case (state)
        IDLE: begin
          if (clrStart) begin
            state       <= CLEAR;
            clrAdr      <= '0;
            clrBusy     <= 1'b1;
            clrColorReg <= clrColor;
          end
        end
        CLEAR: begin
          if (clrGrant) begin
            if (clrAdr == FB_LAST) begin
              state   <= IDLE;
              clrAdr  <= '0;
              clrBusy <= 1'b0;
              clrDone <= 1'b1;
            end else begin
              clrAdr <= clrAdr + 17'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Out-of-range reads never touch the RAM, so their data is forced to zero.
  always_ff @(posedge ckVideo) begin
    if (!rstVideoN) begin
      hostRdValid <= 1'b0;
      rdInRange   <= 1'b0;
    end else begin
      hostRdValid <= hostGrant && !hostWe;
      rdInRange   <= hostInRange;
    end
  end

  assign hostRdData = (hostRdValid && rdInRange) ? memRdData : 16'h0000;

  // The RAM word is valid only one cycle after the slot, so it is latched and
  // held for the four pixels that follow.
  always_ff @(posedge ckVideo) begin
    if (!rstVideoN) begin
      pixSel1      <= '0;
      pixSel2      <= '0;
      act1         <= 1'b0;
      act2         <= 1'b0;
      hs1          <= 1'b1;
      hs2          <= 1'b1;
      vs1          <= 1'b1;
      vs2          <= 1'b1;
      dispPend     <= 1'b0;
      dispWord     <= '0;
      pixOut       <= '0;
      flgActiveOut <= 1'b0;
      HSOut        <= 1'b1;
      VSOut        <= 1'b1;
    end else begin
      pixSel1  <= adrHor[1:0];
      act1     <= flgActiveVideo;
      hs1      <= HS;
      vs1      <= VS;
      dispPend <= dispSlot;

      pixSel2 <= pixSel1;
      act2    <= act1;
      hs2     <= hs1;
      vs2     <= vs1;
      if (dispPend) begin
        dispWord <= memRdData;
      end

      flgActiveOut <= act2;
      HSOut        <= hs2;
      VSOut        <= vs2;
      pixOut       <= act2 ? dispWord[{pixSel2, 2'b00} +: 4] : 4'h0;
    end
  end

endmodule
